// File: rtl/type2_mmrx_dispatch_pkg.sv
// Shared definitions for the TYPE2 receive memory manager: word flags,
// header fields, port count and the dispatch FSM states.
package type2_mmrx_dispatch_pkg;

  localparam int WORD_W      = 18;
  localparam int SOP_BIT     = 17;
  localparam int EOP_BIT     = 16;
  localparam int HDR_STA_HI  = 15;
  localparam int HDR_STA_LO  = 8;
  localparam int HDR_PORT_HI = 7;
  localparam int HDR_PORT_LO = 5;
  localparam int NUM_PORTS   = 4;
  localparam int PORT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } rx_state_e;

  // Header is for us when the station matches and the 3-bit port field names an existing port.
  function automatic logic hdr_match(input logic [WORD_W-1:0] word, input logic [7:0] sta);
    return (word[HDR_STA_HI:HDR_STA_LO] == sta) && (word[HDR_PORT_HI:HDR_PORT_LO] < 3'd4);
  endfunction

endpackage

// File: rtl/type2_rx_port_buf.sv
// One per-port frame buffer: RAM plus committed/shadow write pointers,
// read pointer and committed-frame counter.
module type2_rx_port_buf
  import type2_mmrx_dispatch_pkg::*;
#(
  parameter int DEPTH_W = 8
) (
  input  logic              clk_12_5m,
  input  logic              rst_12_5m_n,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              commit,
  input  logic              abort,
  input  logic              pop,
  output logic [WORD_W-1:0] rd_q,
  output logic              has_data,
  output logic              wp_full,
  output logic              sh_full,
  output logic              frm_zero
);

  localparam int PW = DEPTH_W + 1;
  localparam logic [PW-1:0] ONE_P    = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {DEPTH_W{1'b0}}};

  logic [WORD_W-1:0] mem_r [0:(2**DEPTH_W)-1];
  logic [PW-1:0]     wp_r, sh_r, rp_r, fcnt_r;
  logic [PW-1:0]     wr_base_s, wr_next_s;
  logic [WORD_W-1:0] q_r;
  logic              pop_d_r;

  // An abort rewinds the shadow pointer, so a same-cycle write lands at the committed pointer.
  assign wr_base_s = abort ? wp_r : sh_r;
  assign wr_next_s = wr_base_s + {{DEPTH_W{1'b0}}, wr_en};

  assign rd_q     = q_r;
  assign has_data = (wp_r != rp_r);
  assign wp_full  = ((wp_r ^ rp_r) == FULL_XOR);
  assign sh_full  = ((sh_r ^ rp_r) == FULL_XOR);
  assign frm_zero = (fcnt_r == {PW{1'b0}});

  // RAM write port.
  always_ff @(posedge clk_12_5m) begin
    if (wr_en) begin
      mem_r[wr_base_s[DEPTH_W-1:0]] <= wr_data;
    end
  end

  // Pointers, synchronous read register and frame counter.
  always_ff @(posedge clk_12_5m or negedge rst_12_5m_n) begin
    if (!rst_12_5m_n) begin
      wp_r    <= {PW{1'b0}};
      sh_r    <= {PW{1'b0}};
      rp_r    <= {PW{1'b0}};
      fcnt_r  <= {PW{1'b0}};
      q_r     <= {WORD_W{1'b0}};
      pop_d_r <= 1'b0;
    end else begin
      sh_r    <= wr_next_s;
      wp_r    <= commit ? wr_next_s : wp_r;
      pop_d_r <= pop;
      if (pop) begin
        rp_r <= rp_r + ONE_P;
        q_r  <= mem_r[rp_r[DEPTH_W-1:0]];
      end
      // The eop flag is known once the popped word is in q_r, one cycle after the pop.
      case ({commit, pop_d_r & q_r[EOP_BIT]})
        2'b10:   fcnt_r <= fcnt_r + ONE_P;
        2'b01:   fcnt_r <= fcnt_r - ONE_P;
        default: fcnt_r <= fcnt_r;
      endcase
    end
  end

endmodule

// File: rtl/type2_mmrx_dispatch.sv
// TYPE2 receive memory manager: validates slink frames, dispatches them to
// four per-port buffers with atomic commit, and serves EMIF reads.
module type2_mmrx_dispatch
  import type2_mmrx_dispatch_pkg::*;
#(
  parameter int DEPTH_W = 8,
  parameter int MAX_LEN = 128
) (
  input  logic                 clk_12_5m,
  input  logic                 rst_12_5m_n,
  input  logic [7:0]           self_sta_num,
  input  logic                 slink_mmrx_dval,
  input  logic [WORD_W-1:0]    slink_mmrx_data,
  input  logic                 rd_sel,
  input  logic [PORT_W-1:0]    rd_port,
  input  logic                 rd_en,
  output logic                 rd_dval,
  output logic [WORD_W-1:0]    rd_data,
  output logic [NUM_PORTS-1:0] port_empty,
  output logic [15:0]          drop_cnt,
  output logic                 frm_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  rx_state_e             state_r, nxt_state_s;
  logic [PORT_W-1:0]     port_r, nxt_port_s, hdr_port_s, rd_port_r;
  logic [LEN_W-1:0]      len_r, nxt_len_s;
  logic [NUM_PORTS-1:0]  wr_en_s, commit_s, abort_s, pop_s;
  logic [NUM_PORTS-1:0]  has_data_s, wp_full_s, sh_full_s, frm_zero_s;
  logic [WORD_W-1:0]     rd_q_s [NUM_PORTS];
  logic [1:0]            drops_s;
  logic                  sop_s, eop_s, hdr_ok_s, pop_ok_s;
  logic [16:0]           drop_sum_s;
  logic                  rd_dval_r, frm_err_r;
  logic [NUM_PORTS-1:0]  port_empty_r;
  logic [15:0]           drop_cnt_r;

  assign sop_s      = slink_mmrx_dval & slink_mmrx_data[SOP_BIT];
  assign eop_s      = slink_mmrx_data[EOP_BIT];
  assign hdr_port_s = slink_mmrx_data[HDR_PORT_LO +: PORT_W];
  assign hdr_ok_s   = hdr_match(slink_mmrx_data, self_sta_num) & ~wp_full_s[hdr_port_s];
  assign pop_ok_s   = rd_sel & rd_en & has_data_s[rd_port];
  assign drop_sum_s = {1'b0, drop_cnt_r} + {15'd0, drops_s};

  // Dispatch FSM: frame body handling, then a sop is treated as a fresh header in any state.
  always_comb begin
    nxt_state_s = state_r;
    nxt_port_s  = port_r;
    nxt_len_s   = len_r;
    wr_en_s     = {NUM_PORTS{1'b0}};
    commit_s    = {NUM_PORTS{1'b0}};
    abort_s     = {NUM_PORTS{1'b0}};
    pop_s       = {NUM_PORTS{1'b0}};
    drops_s     = 2'd0;
    pop_s[rd_port] = pop_ok_s;

    case (state_r)
      ST_IDLE: nxt_state_s = ST_IDLE;
      ST_RECV: begin
        if (sop_s) begin
          abort_s[port_r] = 1'b1;
          drops_s         = 2'd1;
        end else if (slink_mmrx_dval) begin
          if ((len_r == LEN_W'(MAX_LEN)) || sh_full_s[port_r]) begin
            abort_s[port_r] = 1'b1;
            drops_s         = 2'd1;
            nxt_state_s     = eop_s ? ST_IDLE : ST_DROP;
          end else begin
            wr_en_s[port_r]  = 1'b1;
            commit_s[port_r] = eop_s;
            nxt_len_s        = len_r + LEN_ONE;
            nxt_state_s      = eop_s ? ST_IDLE : ST_RECV;
          end
        end else begin
          nxt_state_s = ST_RECV;
        end
      end
      ST_DROP: begin
        if (slink_mmrx_dval && !sop_s && eop_s) begin
          nxt_state_s = ST_IDLE;
        end else begin
          nxt_state_s = ST_DROP;
        end
      end
      default: nxt_state_s = ST_IDLE;
    endcase

    if (sop_s) begin
      if (hdr_ok_s) begin
        wr_en_s[hdr_port_s]  = 1'b1;
        commit_s[hdr_port_s] = eop_s;
        nxt_port_s           = hdr_port_s;
        nxt_len_s            = LEN_ONE;
        nxt_state_s          = eop_s ? ST_IDLE : ST_RECV;
      end else begin
        drops_s     = drops_s + 2'd1;
        nxt_state_s = eop_s ? ST_IDLE : ST_DROP;
      end
    end else begin
      drops_s = drops_s;
    end
  end

  // FSM state, read-side and status registers.
  always_ff @(posedge clk_12_5m or negedge rst_12_5m_n) begin
    if (!rst_12_5m_n) begin
      state_r      <= ST_IDLE;
      port_r       <= {PORT_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      rd_port_r    <= {PORT_W{1'b0}};
      rd_dval_r    <= 1'b0;
      port_empty_r <= {NUM_PORTS{1'b1}};
      drop_cnt_r   <= 16'd0;
      frm_err_r    <= 1'b0;
    end else begin
      state_r      <= nxt_state_s;
      port_r       <= nxt_port_s;
      len_r        <= nxt_len_s;
      rd_dval_r    <= pop_ok_s;
      rd_port_r    <= pop_ok_s ? rd_port : rd_port_r;
      port_empty_r <= frm_zero_s;
      drop_cnt_r   <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      frm_err_r    <= (drops_s != 2'd0);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    type2_rx_port_buf #(.DEPTH_W(DEPTH_W)) u_buf (
      .clk_12_5m  (clk_12_5m),
      .rst_12_5m_n(rst_12_5m_n),
      .wr_en      (wr_en_s[g]),
      .wr_data    (slink_mmrx_data),
      .commit     (commit_s[g]),
      .abort      (abort_s[g]),
      .pop        (pop_s[g]),
      .rd_q       (rd_q_s[g]),
      .has_data   (has_data_s[g]),
      .wp_full    (wp_full_s[g]),
      .sh_full    (sh_full_s[g]),
      .frm_zero   (frm_zero_s[g])
    );
  end

  // The RAM read register of the selected port is the data output.
  assign rd_data    = rd_q_s[rd_port_r];
  assign rd_dval    = rd_dval_r;
  assign port_empty = port_empty_r;
  assign drop_cnt   = drop_cnt_r;
  assign frm_err    = frm_err_r;

endmodule

// File: tb/tb_type2_mmrx_dispatch.sv
// Scoreboard bench for type2_mmrx_dispatch: committed frames are queued per
// port when sent and checked word by word as the EMIF side pops them.
module tb_type2_mmrx_dispatch;

  localparam logic [7:0] SELF    = 8'h0A;
  localparam int         MAX_LEN = 128;
  localparam int         DEPTH   = 256;

  logic        clk_12_5m = 1'b0;
  logic        rst_12_5m_n = 1'b0;
  logic [7:0]  self_sta_num = SELF;
  logic        slink_mmrx_dval = 1'b0;
  logic [17:0] slink_mmrx_data = 18'd0;
  logic        rd_sel = 1'b0;
  logic [1:0]  rd_port = 2'd0;
  logic        rd_en = 1'b0;
  logic        rd_dval;
  logic [17:0] rd_data;
  logic [3:0]  port_empty;
  logic [15:0] drop_cnt;
  logic        frm_err;

  typedef logic [17:0] word_q_t[$];
  word_q_t exp_q [4];

  int n_cmp = 0;
  int n_err = 0;
  int exp_drops = 0;
  int frm_pulses = 0;

  type2_mmrx_dispatch #(.DEPTH_W(8), .MAX_LEN(MAX_LEN)) dut (
    .clk_12_5m      (clk_12_5m),
    .rst_12_5m_n    (rst_12_5m_n),
    .self_sta_num   (self_sta_num),
    .slink_mmrx_dval(slink_mmrx_dval),
    .slink_mmrx_data(slink_mmrx_data),
    .rd_sel         (rd_sel),
    .rd_port        (rd_port),
    .rd_en          (rd_en),
    .rd_dval        (rd_dval),
    .rd_data        (rd_data),
    .port_empty     (port_empty),
    .drop_cnt       (drop_cnt),
    .frm_err        (frm_err)
  );

  always #40 clk_12_5m = ~clk_12_5m;

  always @(negedge clk_12_5m) begin
    if (frm_err === 1'b1) frm_pulses++;
  end

  // One clock: inputs were set after a negedge; check any read issued for this edge.
  task automatic step();
    bit          issue;
    bit          ev;
    int          ip;
    logic [17:0] w;
    issue = rst_12_5m_n && rd_sel && rd_en;
    ip    = int'(rd_port);
    ev    = exp_q[ip].size() > 0;
    @(negedge clk_12_5m);
    if (issue) begin
      n_cmp++;
      if (ev) begin
        w = exp_q[ip].pop_front();
        if ({rd_dval, rd_data} !== {1'b1, w}) begin
          n_err++;
          $display("FAIL rd_port%0d: got dval=%b data=%h, want dval=1 data=%h", ip, rd_dval, rd_data, w);
        end
      end else if (rd_dval !== 1'b0) begin
        n_err++;
        $display("FAIL rd_empty_port%0d: got dval=%b, want 0", ip, rd_dval);
      end
    end
  endtask

  task automatic idle(input int n);
    slink_mmrx_dval = 1'b0;
    slink_mmrx_data = 18'd0;
    repeat (n) step();
  endtask

  task automatic drain(input logic [1:0] p, input int n);
    rd_sel = 1'b1; rd_en = 1'b1; rd_port = p;
    repeat (n) step();
    rd_sel = 1'b0; rd_en = 1'b0;
  endtask

  // Sends a frame and records what the spec says must come out of it.
  task automatic send_frame(input logic [15:0] hdr, input int n, input bit with_eop);
    word_q_t     words;
    logic [17:0] w;
    int          p;
    bit          ok;
    for (int i = 0; i < n; i++) begin
      w[17]    = (i == 0);
      w[16]    = with_eop && (i == n - 1);
      w[15:0]  = (i == 0) ? hdr : 16'($urandom);
      words.push_back(w);
      slink_mmrx_dval = 1'b1;
      slink_mmrx_data = w;
      step();
    end
    slink_mmrx_dval = 1'b0;
    slink_mmrx_data = 18'd0;
    p  = int'(hdr[6:5]);
    ok = with_eop && (hdr[15:8] == SELF) && (hdr[7:5] < 3'd4) && (n <= MAX_LEN)
         && (exp_q[p].size() + n <= DEPTH);
    if (ok) begin
      foreach (words[i]) exp_q[p].push_back(words[i]);
    end else begin
      exp_drops++;
    end
  endtask

  task automatic test_reset();
    rst_12_5m_n = 1'b0;
    idle(3);
    n_cmp += 5;
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL reset_port_empty: got %h want f", port_empty); end
    if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL reset_drop_cnt: got %h want 0", drop_cnt); end
    if (rd_dval !== 1'b0) begin n_err++; $display("FAIL reset_rd_dval: got %b want 0", rd_dval); end
    if (rd_data !== 18'd0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    if (frm_err !== 1'b0) begin n_err++; $display("FAIL reset_frm_err: got %b want 0", frm_err); end
    rst_12_5m_n = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame();
    send_frame(16'h0A40, 4, 1'b1);
    idle(2);
    n_cmp++;
    if (port_empty !== 4'b1011) begin n_err++; $display("FAIL good_port_empty: got %b want 1011", port_empty); end
    drain(2'd2, 4);
    idle(4);
    n_cmp++;
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL good_drained: got %b want 1111", port_empty); end
  endtask

  task automatic test_bad_dest();
    int base;
    base = frm_pulses;
    send_frame(16'h0B40, 3, 1'b1);
    send_frame(16'h0AA0, 3, 1'b1);
    idle(3);
    n_cmp += 3;
    if (drop_cnt !== 16'(exp_drops)) begin n_err++; $display("FAIL bad_dest_drop_cnt: got %0d want %0d", drop_cnt, exp_drops); end
    if (frm_pulses - base != 2) begin n_err++; $display("FAIL bad_dest_frm_err: got %0d pulses want 2", frm_pulses - base); end
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL bad_dest_port_empty: got %b want 1111", port_empty); end
  endtask

  task automatic test_oversize();
    send_frame(16'h0A00, 129, 1'b1);
    idle(3);
    n_cmp += 2;
    if (drop_cnt !== 16'(exp_drops)) begin n_err++; $display("FAIL oversize_drop_cnt: got %0d want %0d", drop_cnt, exp_drops); end
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL oversize_port_empty: got %b want 1111", port_empty); end
    send_frame(16'h0A00, 128, 1'b1);
    idle(2);
    n_cmp++;
    if (port_empty !== 4'b1110) begin n_err++; $display("FAIL max_len_port_empty: got %b want 1110", port_empty); end
    drain(2'd0, 128);
    idle(4);
  endtask

  task automatic test_truncation();
    send_frame(16'h0A20, 3, 1'b0);
    send_frame(16'h0A20, 4, 1'b1);
    idle(2);
    n_cmp += 2;
    if (drop_cnt !== 16'(exp_drops)) begin n_err++; $display("FAIL trunc_drop_cnt: got %0d want %0d", drop_cnt, exp_drops); end
    if (port_empty !== 4'b1101) begin n_err++; $display("FAIL trunc_port_empty: got %b want 1101", port_empty); end
    drain(2'd1, 5);
    idle(4);
    n_cmp++;
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL trunc_drained: got %b want 1111", port_empty); end
  endtask

  task automatic test_full_concurrency();
    word_q_t     bq;
    logic [17:0] w;
    send_frame(16'h0A20, 128, 1'b1);
    send_frame(16'h0A20, 128, 1'b1);
    idle(2);
    n_cmp++;
    if (port_empty !== 4'b1101) begin n_err++; $display("FAIL full_port_empty: got %b want 1101", port_empty); end
    send_frame(16'h0A20, 2, 1'b1);
    idle(2);
    n_cmp++;
    if (drop_cnt !== 16'(exp_drops)) begin n_err++; $display("FAIL full_drop_cnt: got %0d want %0d", drop_cnt, exp_drops); end
    drain(2'd1, 256);
    send_frame(16'h0A60, 3, 1'b1);
    idle(1);
    // Frame B arrives while frame A is popped; B's commit coincides with A's eop pop.
    for (int i = 0; i < 4; i++) begin
      w[17]   = (i == 0);
      w[16]   = (i == 3);
      w[15:0] = (i == 0) ? 16'h0A60 : 16'($urandom);
      bq.push_back(w);
      slink_mmrx_dval = 1'b1;
      slink_mmrx_data = w;
      rd_sel  = (i >= 1);
      rd_en   = (i >= 1);
      rd_port = 2'd3;
      step();
    end
    rd_sel = 1'b0; rd_en = 1'b0;
    foreach (bq[i]) exp_q[3].push_back(bq[i]);
    idle(4);
    n_cmp++;
    if (port_empty !== 4'b0111) begin n_err++; $display("FAIL concur_port_empty: got %b want 0111", port_empty); end
    drain(2'd3, 4);
    idle(4);
    n_cmp++;
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL concur_drained: got %b want 1111", port_empty); end
  endtask

  task automatic test_reset_mid_frame();
    logic [17:0] w;
    for (int i = 0; i < 5; i++) begin
      w = {(i == 0), (i == 4), (i == 0) ? 16'h0A40 : 16'($urandom)};
      slink_mmrx_dval = 1'b1;
      slink_mmrx_data = w;
      if (i == 2) begin
        rst_12_5m_n = 1'b0;
        idle(2);
        for (int p = 0; p < 4; p++) exp_q[p].delete();
        exp_drops = 0;
        n_cmp += 2;
        if (port_empty !== 4'hF) begin n_err++; $display("FAIL midreset_port_empty: got %b want 1111", port_empty); end
        if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midreset_drop_cnt: got %0d want 0", drop_cnt); end
        rst_12_5m_n = 1'b1;
        idle(1);
      end else begin
        step();
      end
    end
    idle(2);
    send_frame(16'h0A40, 5, 1'b1);
    idle(2);
    n_cmp += 2;
    if (port_empty !== 4'b1011) begin n_err++; $display("FAIL midreset_new_frame: got %b want 1011", port_empty); end
    if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL midreset_tail_drop: got %0d want 0", drop_cnt); end
    drain(2'd2, 5);
    idle(4);
    n_cmp++;
    if (port_empty !== 4'hF) begin n_err++; $display("FAIL midreset_drained: got %b want 1111", port_empty); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_dest();
    test_oversize();
    test_truncation();
    test_full_concurrency();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
